// File: rtl/acq_address_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// acq_pkg
// Shared types and constants for the BRAM acquisition address sequencer:
//   acq_state_t      - capture control FSM states
//   ACQ_COUNT_WIDTH  - width of the completed-capture counter
// -----------------------------------------------------------------------------
package acq_pkg;

    localparam int ACQ_COUNT_WIDTH = 32;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ARMED     = 3'd1,
        WAIT_WRAP = 3'd2,
        CAPTURE   = 3'd3,
        DONE      = 3'd4
    } acq_state_t;

endpackage

// File: rtl/acq_address_sequencer_if.sv
// -----------------------------------------------------------------------------
// acq_address_sequencer_if
// Control and status bundle between the register map / trigger logic and the
// address sequencer.
//   trig_mode, arm, sw_trig, ext_trig   : control into the sequencer
//   address, address_dly                : BRAM address and its delayed copy
//   start_acq                           : one-cycle capture launch pulse
//   busy, done, acq_count               : capture status
// Modports: master drives control and reads status, slave is the sequencer.
// -----------------------------------------------------------------------------
interface acq_address_sequencer_if
    import acq_pkg::*;
#(
    parameter int BRAM_WIDTH = 13
) ();

    logic                       trig_mode;
    logic                       arm;
    logic                       sw_trig;
    logic                       ext_trig;
    logic [BRAM_WIDTH-1:0]      address;
    logic [BRAM_WIDTH-1:0]      address_dly;
    logic                       start_acq;
    logic                       busy;
    logic                       done;
    logic [ACQ_COUNT_WIDTH-1:0] acq_count;

    modport master (
        output trig_mode, arm, sw_trig, ext_trig,
        input  address, address_dly, start_acq, busy, done, acq_count
    );

    modport slave (
        input  trig_mode, arm, sw_trig, ext_trig,
        output address, address_dly, start_acq, busy, done, acq_count
    );

endinterface

// File: rtl/acq_address_sequencer_delay_line.sv
// -----------------------------------------------------------------------------
// delay_line
// Generic register pipeline: q_o is d_i delayed by DEPTH clock cycles.
// Synchronous active-high reset clears every stage to 0.
//   clk  : clock
//   rst  : synchronous active-high reset
//   d_i  : WIDTH-bit input
//   q_o  : WIDTH-bit output, DEPTH cycles behind d_i
// DEPTH must be at least 1.
// -----------------------------------------------------------------------------
module delay_line #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [DEPTH-1:0][WIDTH-1:0] stage_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= '0;
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/acq_address_sequencer.sv
// -----------------------------------------------------------------------------
// acq_address_sequencer
// Free-running BRAM address generator plus single-frame capture control.
// A capture is armed by 'arm', fired by a software pulse or the rising edge of
// the external trigger, waits for the next address wrap and then spans exactly
// one frame (2^BRAM_WIDTH cycles).
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : acq_address_sequencer_if.slave (control in, address/status out)
// Parameters:
//   BRAM_WIDTH : address width, one frame = 2^BRAM_WIDTH samples
//   ADDR_DELAY : depth of the address_dly pipeline (1..8); 2 lines it up with
//                the downstream write-enable
// -----------------------------------------------------------------------------
module acq_address_sequencer
    import acq_pkg::*;
#(
    parameter int BRAM_WIDTH = 13,
    parameter int ADDR_DELAY = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    acq_address_sequencer_if.slave  bus
);

    localparam logic [BRAM_WIDTH-1:0] ADDR_LAST = '1;

    logic [BRAM_WIDTH-1:0]      address_q;
    logic [BRAM_WIDTH-1:0]      address_d;
    logic [BRAM_WIDTH-1:0]      address_dly_w;
    logic                       ext_trig_q;
    logic                       ext_edge;
    logic                       trig;

    acq_state_t                 state_q;
    logic [BRAM_WIDTH-1:0]      cap_cnt_q;
    logic [BRAM_WIDTH-1:0]      cap_cnt_d;
    logic                       start_acq_q;
    logic                       busy_q;
    logic                       done_q;
    logic [ACQ_COUNT_WIDTH-1:0] acq_count_q;
    logic [ACQ_COUNT_WIDTH-1:0] acq_count_d;

    // Address counter: never stalls, wraps naturally at 2^BRAM_WIDTH.
    assign address_d = address_q + BRAM_WIDTH'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            address_q  <= '0;
            ext_trig_q <= 1'b0;
        end else begin
            address_q  <= address_d;
            ext_trig_q <= bus.ext_trig;
        end
    end

    // Edge detect is combinational on the registered copy, so an ext_trig
    // rise sampled at edge t launches start_acq in cycle t+1.
    assign ext_edge = bus.ext_trig & ~ext_trig_q;
    assign trig     = bus.trig_mode ? ext_edge : bus.sw_trig;

    assign cap_cnt_d   = cap_cnt_q + BRAM_WIDTH'(1);
    assign acq_count_d = acq_count_q + ACQ_COUNT_WIDTH'(1);

    // Capture control FSM with registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cap_cnt_q   <= '0;
            start_acq_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            acq_count_q <= '0;
        end else begin
            start_acq_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.arm) begin
                        state_q <= ARMED;
                    end
                end
                ARMED: begin
                    if (trig) begin
                        state_q     <= WAIT_WRAP;
                        start_acq_q <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                WAIT_WRAP: begin
                    // The start_acq cycle itself never counts as the wrap: the
                    // downstream stage only starts running one cycle later, so
                    // a coincident address 0 costs a whole frame of waiting.
                    if (!start_acq_q && (address_q == '0)) begin
                        state_q   <= CAPTURE;
                        cap_cnt_q <= '0;
                    end
                end
                CAPTURE: begin
                    cap_cnt_q <= cap_cnt_d;
                    if (cap_cnt_q == ADDR_LAST) begin
                        state_q     <= DONE;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        acq_count_q <= acq_count_d;
                    end
                end
                DONE: begin
                    if (bus.arm) begin
                        state_q <= ARMED;
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    delay_line #(
        .WIDTH (BRAM_WIDTH),
        .DEPTH (ADDR_DELAY)
    ) u_addr_dly (
        .clk (clk),
        .rst (rst),
        .d_i (address_q),
        .q_o (address_dly_w)
    );

    assign bus.address     = address_q;
    assign bus.address_dly = address_dly_w;
    assign bus.start_acq   = start_acq_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.acq_count   = acq_count_q;

endmodule

// File: tb/tb_acq_address_sequencer.sv
// -----------------------------------------------------------------------------
// tb_acq_address_sequencer
// Drives acq_address_sequencer with randomized trigger/arm noise around a set
// of capture scenarios and compares every output, every cycle, against a
// cycle-indexed reference model: the address is the cycle number modulo the
// frame size, and each capture is described by its start cycle and the cycle
// at which it completes, computed arithmetically from the wrap rules.
// -----------------------------------------------------------------------------
module tb_acq_address_sequencer;
    import acq_pkg::*;

    localparam int W     = 13;
    localparam int FRAME = 1 << W;
    localparam int DLY   = 2;

    logic clk = 1'b0;
    logic rst;

    acq_address_sequencer_if #(.BRAM_WIDTH(W)) bus ();

    acq_address_sequencer #(
        .BRAM_WIDTH (W),
        .ADDR_DELAY (DLY)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model state. m_n is the index of the current cycle since the
    // last reset edge (cycle 0 shows address 0).
    int          m_n       = 0;
    bit          m_armed   = 1'b0;
    bit          m_busy    = 1'b0;
    bit          m_done    = 1'b0;
    int          m_start   = 0;
    int          m_end     = 0;
    logic [31:0] m_count   = '0;
    bit          m_ext_prev = 1'b0;

    int n_checks = 0;
    int n_fails  = 0;
    int n_starts = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: observed %0h expected %0h (model cycle %0d)", tag, obs, exp, m_n);
        end
    endtask

    // Apply one clock edge to the model using the inputs the DUT samples.
    task automatic model_edge();
        bit trig;
        if (rst) begin
            m_n        = 0;
            m_armed    = 1'b0;
            m_busy     = 1'b0;
            m_done     = 1'b0;
            m_count    = '0;
            m_ext_prev = 1'b0;
            return;
        end
        trig       = bus.trig_mode ? (bus.ext_trig && !m_ext_prev) : bus.sw_trig;
        m_ext_prev = bus.ext_trig;
        if (m_busy) begin
            if (m_n + 1 == m_end) begin
                m_busy  = 1'b0;
                m_done  = 1'b1;
                m_count = m_count + 32'd1;
            end
        end else if (m_armed && trig) begin
            m_armed = 1'b0;
            m_busy  = 1'b1;
            m_start = m_n + 1;
            // Capture starts after the first address-0 cycle strictly after
            // the start cycle, lasts one frame, and done shows the cycle after.
            m_end   = ((m_start / FRAME) + 1) * FRAME + FRAME + 1;
        end else if (bus.arm && !m_armed) begin
            m_armed = 1'b1;
            m_done  = 1'b0;
        end
        m_n++;
    endtask

    task automatic check_outputs();
        int exp_dly;
        exp_dly = (m_n >= DLY) ? ((m_n - DLY) % FRAME) : 0;
        check_eq("address",     64'(bus.address),     64'(m_n % FRAME));
        check_eq("address_dly", 64'(bus.address_dly), 64'(exp_dly));
        check_eq("start_acq",   64'(bus.start_acq),   64'(m_busy && (m_n == m_start)));
        check_eq("busy",        64'(bus.busy),        64'(m_busy));
        check_eq("done",        64'(bus.done),        64'(m_done));
        check_eq("acq_count",   64'(bus.acq_count),   64'(m_count));
        if (bus.start_acq === 1'b1) n_starts++;
    endtask

    // One clock cycle with the given arm / sw_trig / ext_trig values.
    task automatic cyc(input bit a, input bit s, input bit e);
        bus.arm      = a;
        bus.sw_trig  = s;
        bus.ext_trig = e;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic rnd_bit(output bit b, input int one_in);
        b = ($urandom_range(0, one_in - 1) == 0);
    endtask

    // Run with trigger/arm noise until the model capture completes.
    task automatic run_until_done(input bit ext_noise);
        int k;
        bit a, s, e;
        k = 0;
        while (m_busy && k < 3 * FRAME) begin
            rnd_bit(a, 16);
            rnd_bit(s, 8);
            e = ext_noise ? 1'($urandom_range(0, 1)) : 1'b0;
            cyc(a, s, e);
            k++;
        end
        if (k >= 3 * FRAME) check_eq("capture_budget", 64'(bus.done), 64'd1);
    endtask

    task automatic run_to_addr(input int target);
        int k;
        k = 0;
        while ((m_n % FRAME) != target && k < 2 * FRAME) begin
            cyc(1'b0, 1'b0, 1'($urandom_range(0, 1)));
            k++;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit s, e;
        int target;
        rst           = 1'b1;
        bus.trig_mode = 1'b0;
        bus.arm       = 1'b0;
        bus.sw_trig   = 1'b0;
        bus.ext_trig  = 1'b0;

        // Reset for three cycles, then free-run with unarmed trigger noise.
        repeat (3) cyc(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            bus.trig_mode = 1'($urandom_range(0, 1));
            rnd_bit(s, 3);
            rnd_bit(e, 2);
            cyc(1'b0, s, e);
        end
        check_eq("unarmed_idle_busy", 64'(bus.busy), 64'd0);

        // Software capture fired at address 100.
        bus.trig_mode = 1'b0;
        cyc(1'b1, 1'b0, 1'b0);
        run_to_addr(100);
        n_starts = 0;
        cyc(1'b0, 1'b1, 1'b0);
        check_eq("sw_start_addr", 64'(bus.address), 64'd101);
        run_until_done(1'b0);
        check_eq("sw_start_pulses", 64'(n_starts), 64'd1);
        check_eq("sw_done", 64'(bus.done), 64'd1);
        check_eq("sw_acq_count", 64'(bus.acq_count), 64'd1);

        // Sticky done: triggers without arm do nothing.
        for (int i = 0; i < 20; i++) begin
            rnd_bit(s, 2);
            cyc(1'b0, s, 1'b0);
        end
        check_eq("done_sticky", 64'(bus.done), 64'd1);

        // Rearm, then make start_acq coincide with address 0.
        cyc(1'b1, 1'b0, 1'b0);
        check_eq("arm_clears_done", 64'(bus.done), 64'd0);
        run_to_addr(FRAME - 1);
        n_starts = 0;
        cyc(1'b0, 1'b1, 1'b0);
        check_eq("wrap_start_addr", 64'(bus.address), 64'd0);
        check_eq("wrap_start_pulse", 64'(bus.start_acq), 64'd1);
        run_until_done(1'b0);
        check_eq("wrap_start_pulses", 64'(n_starts), 64'd1);
        check_eq("wrap_acq_count", 64'(bus.acq_count), 64'd2);

        // External edge mode: sw_trig ignored, one start for a long high level.
        bus.trig_mode = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        repeat ($urandom_range(5, 200)) begin
            rnd_bit(s, 2);
            cyc(1'b0, s, 1'b0);
        end
        check_eq("ext_mode_sw_ignored", 64'(bus.busy), 64'd0);
        n_starts = 0;
        repeat (50) begin
            rnd_bit(s, 2);
            cyc(1'b0, s, 1'b1);
        end
        cyc(1'b0, 1'b0, 1'b0);
        check_eq("ext_start_pulses", 64'(n_starts), 64'd1);
        run_until_done(1'b1);
        check_eq("ext_start_total", 64'(n_starts), 64'd1);
        check_eq("ext_acq_count", 64'(bus.acq_count), 64'd3);

        // Arm in DONE at edge t, trigger at edge t+1 is accepted.
        bus.trig_mode = 1'b0;
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        check_eq("rearm_next_trig_start", 64'(bus.start_acq), 64'd1);
        check_eq("rearm_next_trig_busy", 64'(bus.busy), 64'd1);

        // Reset in the middle of the capture window.
        target = ((m_start / FRAME) + 1) * FRAME + $urandom_range(10, 500);
        while (m_n < target) begin
            rnd_bit(s, 4);
            cyc(1'b0, s, 1'b0);
        end
        rst = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        check_eq("midreset_busy", 64'(bus.busy), 64'd0);
        check_eq("midreset_done", 64'(bus.done), 64'd0);
        check_eq("midreset_count", 64'(bus.acq_count), 64'd0);
        check_eq("midreset_address", 64'(bus.address), 64'd0);
        for (int i = 0; i < 30; i++) begin
            rnd_bit(s, 2);
            cyc(1'b0, s, 1'b0);
        end
        check_eq("post_reset_trig_ignored", 64'(bus.busy), 64'd0);

        // arm and trig together in IDLE: arm wins, the next trig fires.
        cyc(1'b1, 1'b1, 1'b0);
        check_eq("arm_trig_same_cycle", 64'(bus.busy), 64'd0);
        cyc(1'b0, 1'b1, 1'b0);
        check_eq("trig_after_arm_start", 64'(bus.start_acq), 64'd1);
        repeat (20) cyc(1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
